// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer: walks a register-file index range through one read port
// and emits each word as an in-order valid/ready beat.
module reg_dump_streamer #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  first_idx,
  input  logic [IDX_W-1:0]  last_idx,
  output logic [IDX_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      last     <= '0;
      out_data <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (first_idx <= last_idx) begin
              idx   <= first_idx;
              last  <= last_idx;
              state <= S_FETCH;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          out_data <= rd_data;
          out_idx  <= idx;
          out_last <= (idx == last);
          state    <= S_SEND;
        end
        S_SEND: begin
          // compare before increment so last index 2**IDX_W-1 never wraps
          if (out_ready) begin
            if (out_last) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid = (state == S_SEND);
  assign busy      = (state == S_FETCH) || (state == S_SEND);
  assign done      = (state == S_DONE);
  assign rd_addr   = (state == S_FETCH) ? idx : '0;

endmodule

// File: doc/reg_dump_streamer.md
# reg_dump_streamer

Sequential read-out engine that sits directly downstream of the register file in the datapath. On a start pulse it walks a contiguous index range of the register file through a single combinational read port. Each register word is emitted as one beat on a valid/ready stream, so a bench monitor or serial link can consume final architectural state without 32 parallel taps. It is one-word-in-flight and strictly in-order.

## Interface
- `DATA_W`, default 32: register word width.
- `IDX_W`, default 5: register index width (`2**IDX_W` registers).

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- `first_idx`  in  IDX_W  first register index, sampled with `start`.
- `last_idx`  in  IDX_W  last register index (inclusive), sampled with `start`.
- `rd_addr`  out  IDX_W  read address to the register file read port.
- `rd_data`  in  DATA_W  combinational read data for `rd_addr`.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  consumer accepts beat.
- `out_data`  out  DATA_W  register value of current beat.
- `out_idx`  out  IDX_W  register index of current beat.
- `out_last`  out  1  current beat is index `last_idx`.
- `busy`  out  1  high in FETCH and SEND.
- `done`  out  1  one-cycle pulse after the last beat is accepted.
- `err`  out  1  one-cycle pulse when a start is rejected because `first_idx > last_idx`.

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE, `start`=1, `first_idx <= last_idx`:
  - latch `idx <= first_idx` and `last <= last_idx`;
  - go to FETCH.
- IDLE, `start`=1, `first_idx > last_idx`:
  - assert `err` the next cycle for exactly one cycle;
  - stay in IDLE; no beats.
- FETCH:
  - drive `rd_addr = idx`;
  - at the clock edge, capture `rd_data` into `out_data` and `idx` into `out_idx`;
  - set `out_last = (idx == last)`;
  - go to SEND.
- SEND:
  - `out_valid`=1; `out_data`, `out_idx` and `out_last` are held stable until the handshake.
  - On `out_valid && out_ready`: if `out_last`, go to DONE; else `idx <= idx + 1` and go to FETCH.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored; `first_idx` and `last_idx` are not resampled.
- Index arithmetic is unsigned IDX_W:
  - the termination compare happens before the increment, so `last_idx`=31 never wraps to 0;
  - the beat count is exactly `last_idx - first_idx + 1`, from 1 to `2**IDX_W`.
- `rd_addr` is 0 in every state except FETCH.
- The block never writes the register file.
- Data is sampled in FETCH only. A register-file write in the same cycle follows the register file's own read-during-write behaviour. The captured value is not refreshed in SEND.

## Timing
- Reset (`rst`=0, asynchronous, effective immediately and mid-operation):
  - state=IDLE;
  - `out_valid`, `out_last`, `busy`, `done`, `err` = 0;
  - `out_data`, `out_idx`, `rd_addr`, `idx` = 0.
  - A dump interrupted by reset is abandoned: no `done`, and no further beats after release.
- Start to first `out_valid`: 2 cycles. Start is seen at edge N, FETCH runs in cycle N+1, `out_valid`=1 from edge N+2.
- With `out_ready` held at 1, a beat is accepted every 2 cycles.
- Handshake to next `out_valid`: 2 cycles (FETCH in between).
- `done` is asserted the cycle after the last handshake, and `busy` drops in the same cycle.
- The earliest next `start` is accepted the cycle after `done`.
- `busy` is high from the cycle after an accepted start through the cycle of the last handshake.
- `out_valid` must not drop without a handshake. Backpressure of any length holds SEND.

## Test plan
- Full dump, register file preloaded with reg[i]=i*3, `first_idx`=0, `last_idx`=31, `out_ready`=1:
  - 32 beats, `out_idx` 0..31, `out_data` 0,3,…,93;
  - `out_last` only on index 31;
  - `done` pulse 64 cycles after `start`, with no wrap to index 0.
- Single word, `first_idx`=`last_idx`=7, reg[7]=32'hDEAD_BEEF:
  - exactly one beat, `out_data`=DEADBEEF, `out_idx`=7, `out_last`=1;
  - `done` pulse on the following cycle.
- Backpressure, range 2..4, `out_ready` low 5 cycles on every beat:
  - `out_data`, `out_idx` and `out_last` stable while stalled;
  - 3 beats in order;
  - `busy` continuous until the last handshake.
- Bad range, `first_idx`=9, `last_idx`=3:
  - `err` for one cycle;
  - `busy`, `out_valid`, `done` stay 0.
- `start` pulsed with range 0..1 while a 10..20 dump is busy:
  - ignored; beats 10..20 only, single `done`.
- Assert `rst`=0 during SEND of a 0..31 dump:
  - all outputs go to 0 immediately;
  - after release, no beats until a new `start`.
